// File: rtl/bcp_implication_scheduler.sv
// BCP implication scheduler: captures a pending-lane vector and issues lanes highest index first.
// Optional build macro BCP_SCHED_MERGE_EN lets new requests merge into a vector that is still issuing.
module bcp_implication_scheduler #(
    parameter int WIDTH = 8,
    parameter int IDX_W = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_vec,
    output logic             load_ready,
    output logic             issue_valid,
    output logic [IDX_W-1:0] issue_idx,
    input  logic             issue_ready,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic [IDX_W:0]   issued_count,
    output logic [1:0]       state_dbg
);
    // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
    // Once raised, valid and its payload hold until that edge, and abort in the same cycle cancels the transfer.
    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, DONE = 2'd2} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pending_q, pending_d, pending_nxt, grant;
    logic [IDX_W:0]   count_q, count_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             handshake;

    function automatic logic [IDX_W-1:0] hi_idx(input logic [WIDTH-1:0] v);
        hi_idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (v[i]) hi_idx = IDX_W'(i);
        end
    endfunction

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            pending_q <= '0;
            count_q   <= '0;
            idx_q     <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            count_q   <= count_d;
            idx_q     <= idx_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        count_d     = count_q;
        pending_nxt = pending_q;
        handshake   = (state_q == ISSUE) && issue_ready;
        grant       = {{(WIDTH-1){1'b0}}, 1'b1} << idx_q;
        case (state_q)
            IDLE: begin
                if (load_valid) begin
                    count_d = '0;
                    if (load_vec != '0) begin
                        pending_d = load_vec;
                        state_d   = ISSUE;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            ISSUE: begin
                if (handshake) begin
                    pending_nxt = pending_q & ~grant;
                    if (count_q < (IDX_W+1)'(WIDTH)) count_d = count_q + 1'b1;
                end
`ifdef BCP_SCHED_MERGE_EN
                // OR-ing after the clear re-queues a merged bit equal to the lane just granted.
                if (load_valid) pending_nxt = pending_nxt | load_vec;
`endif
                pending_d = pending_nxt;
                if (pending_nxt == '0) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (abort) begin
            state_d   = IDLE;
            pending_d = '0;
            count_d   = count_q;
        end
        // The offered index is frozen while waiting for ready, so a merge cannot retarget it.
        idx_d = (state_q == ISSUE && !handshake && !abort) ? idx_q : hi_idx(pending_d);
    end

`ifdef BCP_SCHED_MERGE_EN
    assign load_ready = (state_q == IDLE) || (state_q == ISSUE);
`else
    assign load_ready = (state_q == IDLE);
`endif
    assign issue_valid  = (state_q == ISSUE);
    assign issue_idx    = idx_q;
    assign busy         = (state_q != IDLE);
    assign done         = (state_q == DONE);
    assign issued_count = count_q;
    assign state_dbg    = state_q;
endmodule

// File: tb/tb_bcp_implication_scheduler.sv
// Directed bench for bcp_implication_scheduler: issued indices are checked against an expected queue.
// Build with BCP_SCHED_MERGE_EN defined to also exercise the merge path.
module tb_bcp_implication_scheduler;
    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       load_valid = 1'b0;
    logic [7:0] load_vec = 8'h00;
    logic       load_ready;
    logic       issue_valid;
    logic [2:0] issue_idx;
    logic       issue_ready = 1'b0;
    logic       abort = 1'b0;
    logic       busy;
    logic       done;
    logic [3:0] issued_count;
    logic [1:0] state_dbg;

    int checks = 0;
    int failures = 0;
    logic [2:0] exp_q[$];

    bcp_implication_scheduler #(.WIDTH(8), .IDX_W(3)) dut (
        .clock(clock), .reset(reset), .load_valid(load_valid), .load_vec(load_vec),
        .load_ready(load_ready), .issue_valid(issue_valid), .issue_idx(issue_idx),
        .issue_ready(issue_ready), .abort(abort), .busy(busy), .done(done),
        .issued_count(issued_count), .state_dbg(state_dbg)
    );

    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL timeout observed=running required=finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: a handshake seen before the edge pops and checks the scoreboard.
    task automatic tick();
        logic       hs;
        logic [2:0] idx;
        hs  = issue_valid && issue_ready && !abort && !reset;
        idx = issue_idx;
        @(posedge clock);
        #1;
        if (hs) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                failures++;
                $error("FAIL issue_extra observed=%0d expected=none", idx);
            end
            if (exp_q.size() != 0) begin
                logic [2:0] e;
                e = exp_q.pop_front();
                chk("issue_idx", idx, e);
            end
        end
    endtask

    task automatic load(input logic [7:0] v);
        load_valid = 1'b1;
        load_vec   = v;
        tick();
        load_valid = 1'b0;
        load_vec   = 8'h00;
    endtask

    initial begin
        #2;
        chk("rst_load_ready", load_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_issue_valid", issue_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_count", issued_count, 0);
        chk("rst_idx", issue_idx, 0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        tick();

        // T2: sparse vector, ready high
        issue_ready = 1'b1;
        exp_q.push_back(3'd7); exp_q.push_back(3'd5); exp_q.push_back(3'd2);
        load(8'b1010_0100);
        chk("t2_valid_n1", issue_valid, 1);
        chk("t2_idx_n1", issue_idx, 7);
        tick(); tick(); tick();
        chk("t2_done", done, 1);
        chk("t2_count", issued_count, 3);
        chk("t2_q_empty", exp_q.size(), 0);
        tick();
        chk("t2_done_clear", done, 0);
        chk("t2_idle", busy, 0);

        // T3: back-pressure holds the index
        issue_ready = 1'b0;
        exp_q.push_back(3'd1); exp_q.push_back(3'd0);
        load(8'b0000_0011);
`ifndef BCP_SCHED_MERGE_EN
        chk("t3_load_ready_busy", load_ready, 0);
        load_valid = 1'b1;
        load_vec   = 8'h80;
`endif
        for (int i = 0; i < 4; i++) begin
            chk("t3_hold_valid", issue_valid, 1);
            chk("t3_hold_idx", issue_idx, 1);
            tick();
        end
        load_valid  = 1'b0;
        load_vec    = 8'h00;
        issue_ready = 1'b1;
        tick(); tick();
        chk("t3_done", done, 1);
        chk("t3_count", issued_count, 2);
        chk("t3_q_empty", exp_q.size(), 0);
        tick();

        // T4: empty vector
        load(8'h00);
        chk("t4_done", done, 1);
        chk("t4_no_issue", issue_valid, 0);
        chk("t4_count", issued_count, 0);
        tick();
        chk("t4_done_clear", done, 0);

        // T5: abort coincident with third handshake
        exp_q.push_back(3'd7); exp_q.push_back(3'd6);
        load(8'hFF);
        tick(); tick();
        chk("t5_idx_before_abort", issue_idx, 5);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t5_busy", busy, 0);
        chk("t5_done", done, 0);
        chk("t5_count", issued_count, 2);
        chk("t5_issue_valid", issue_valid, 0);
        chk("t5_pending_idx", issue_idx, 0);
        chk("t5_q_empty", exp_q.size(), 0);
        tick();
        chk("t5_no_done_later", done, 0);

        // Full vector: 8 issues in N+1..N+8, done at N+9, count saturates at 8
        for (int i = 7; i >= 0; i--) exp_q.push_back(3'(i));
        load(8'hFF);
        for (int i = 0; i < 8; i++) begin
            chk("full_valid", issue_valid, 1);
            tick();
        end
        chk("full_done", done, 1);
        chk("full_count", issued_count, 8);
        chk("full_q_empty", exp_q.size(), 0);
        tick();
        chk("full_idle", busy, 0);
        chk("full_count_hold", issued_count, 8);

        // T1: reset mid-operation acts without a clock edge
        exp_q.push_back(3'd7);
        load(8'hF0);
        tick();
        #1;
        reset = 1'b1;
        #1;
        chk("t1_load_ready", load_ready, 1);
        chk("t1_busy", busy, 0);
        chk("t1_issue_valid", issue_valid, 0);
        chk("t1_count", issued_count, 0);
        chk("t1_idx", issue_idx, 0);
        chk("t1_done", done, 0);
        exp_q.delete();
        tick();
        reset = 1'b0;
        tick();
        chk("t1_stays_idle", busy, 0);

`ifdef BCP_SCHED_MERGE_EN
        // T6: merge re-queues the lane just granted
        exp_q.push_back(3'd4); exp_q.push_back(3'd4); exp_q.push_back(3'd0);
        load(8'b0001_0000);
        chk("t6_load_ready_issue", load_ready, 1);
        load(8'b0001_0001);
        tick(); tick();
        chk("t6_done", done, 1);
        chk("t6_count", issued_count, 3);
        chk("t6_q_empty", exp_q.size(), 0);
        tick();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
